normalizador_seq: RTL



---
 rtl/normalizador_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/normalizador_seq.sv
// normalizador_seq: iterative shift-add normaliser.
// Multiplies an unsigned WIDTH-bit operand by a programmable reciprocal scale,
// one multiplier bit per clock, and returns the WIDTH-bit slice of the full
// product starting at bit FRAC_SHIFT. ovf flags any product bit above the slice.
// Optional build macro NORMALIZADOR_SAT_EN: when defined, Y saturates to all
// ones whenever ovf is set; otherwise Y is the raw (wrapped) slice.
module normalizador_seq #(
    parameter int              WIDTH      = 32,
    parameter int              FRAC_SHIFT = 22,
    parameter logic [WIDTH-1:0] SCALE_RST = 32'h0038_9374
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scale_wr,
    input  logic [WIDTH-1:0] scale_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    // Product bits above the result slice; empty when the slice reaches the top.
    localparam logic [PW-1:0] HI_MASK =
        ~((PW'(1) << (FRAC_SHIFT + WIDTH)) - PW'(1));

    // Slice must fit inside the double-width product.
    if ((FRAC_SHIFT < 0) || (FRAC_SHIFT + WIDTH > 2 * WIDTH)) begin : g_bad_cfg
        $error("normalizador_seq: FRAC_SHIFT+WIDTH must not exceed 2*WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] scale_r;
    logic [PW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [PW-1:0]    acc_r;
    logic [CW-1:0]    cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] y_r;
    logic             ovf_r;

    logic [PW-1:0]    partial_s;
    logic [PW-1:0]    acc_next_s;
    logic             ovf_s;
    logic [WIDTH-1:0] y_s;
    logic             last_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign Y         = y_r;
    assign ovf       = ovf_r;

    // One shift-add step plus the result slice and overflow of the stepped sum.
    always_comb begin
        partial_s  = mplier_r[0] ? mcand_r : {PW{1'b0}};
        acc_next_s = acc_r + partial_s;
        ovf_s      = |(acc_next_s & HI_MASK);
`ifdef NORMALIZADOR_SAT_EN
        y_s        = ovf_s ? {WIDTH{1'b1}} : acc_next_s[FRAC_SHIFT +: WIDTH];
`else
        y_s        = acc_next_s[FRAC_SHIFT +: WIDTH];
`endif
        last_s     = (cnt_r == CW'(WIDTH - 1));
    end

    // Scale register: writable in every state; an operation samples it on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_r <= SCALE_RST;
        end else if (scale_wr) begin
            scale_r <= scale_in;
        end else begin
            scale_r <= scale_r;
        end
    end

    // Control FSM with working registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mcand_r     <= {PW{1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            acc_r       <= {PW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            y_r         <= {WIDTH{1'b0}};
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        mcand_r    <= {{WIDTH{1'b0}}, A};
                        mplier_r   <= scale_r;
                        acc_r      <= {PW{1'b0}};
                        cnt_r      <= {CW{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= MUL;
                    end else begin
                        in_ready_r <= 1'b1;
                        state_r    <= IDLE;
                    end
                end
                MUL: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_s) begin
                        y_r         <= y_s;
                        ovf_r       <= ovf_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r     <= MUL;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule
